// File: rtl/dspl_scan_drv.sv
// Multiplexed common-anode 7-segment scan driver: per-frame input snapshot,
// anode dead time, 16-level PWM brightness and per-digit blinking.
module dspl_scan_drv #(
    parameter int NUM_DIGITS    = 8,
    parameter int CLK_PER_DIGIT = 100000,
    parameter int BLANK_CYCLES  = 1000,
    parameter int BLINK_FRAMES  = 250
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7*NUM_DIGITS-1:0] dig_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              dec_ddp,
    output logic                    frame_tick
);

    localparam int CW = (CLK_PER_DIGIT > 1) ? $clog2(CLK_PER_DIGIT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Wide enough for CLK_PER_DIGIT*16 without wrap.
    localparam int PW = CW + 5;

    function automatic logic [6:0] glyph_seg(input logic [4:0] code);
        case (code)
            5'h00:   glyph_seg = 7'b0000001;
            5'h01:   glyph_seg = 7'b1001111;
            5'h02:   glyph_seg = 7'b0010010;
            5'h03:   glyph_seg = 7'b0000110;
            5'h04:   glyph_seg = 7'b1001100;
            5'h05:   glyph_seg = 7'b1000111;
            5'h06:   glyph_seg = 7'b0100100;
            5'h07:   glyph_seg = 7'b0110000;
            5'h08:   glyph_seg = 7'b0001111;
            5'h09:   glyph_seg = 7'b1000001;
            5'h0A:   glyph_seg = 7'b0011000;
            5'h0B:   glyph_seg = 7'b1100000;
            5'h0C:   glyph_seg = 7'b0110001;
            5'h0D:   glyph_seg = 7'b1110001;
            5'h0E:   glyph_seg = 7'b1000100;
            5'h0F:   glyph_seg = 7'b0100001;
            default: glyph_seg = 7'b1111111;
        endcase
    endfunction

    logic [CW-1:0]           cnt_p0;
    logic [IW-1:0]           idx_p0;
    logic [FW-1:0]           frm_cnt;
    logic                    blink_ph;
    logic                    primed;
    logic [7*NUM_DIGITS-1:0] sh_dig;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic [3:0]              sh_bright;

    logic                    cnt_wrap, idx_wrap, snap;
    logic [6:0]              cur_dig;
    logic                    cur_blink;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [CW-1:0]           off_p0;
    logic [PW-1:0]           pwm_lhs, pwm_rhs;
    logic                    lit_p0;

    assign cnt_wrap = (cnt_p0 == CW'(CLK_PER_DIGIT - 1));
    assign idx_wrap = (idx_p0 == IW'(NUM_DIGITS - 1));
    assign snap     = cnt_wrap && idx_wrap;

    always_comb begin
        cur_dig   = '0;
        cur_blink = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_p0 == IW'(i)) begin
                cur_dig   = sh_dig[7*i +: 7];
                cur_blink = sh_blink[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    assign off_p0  = cnt_p0 - CW'(BLANK_CYCLES);
    assign pwm_lhs = PW'({off_p0, 4'b0000});
    assign pwm_rhs = PW'(CLK_PER_DIGIT - BLANK_CYCLES) * PW'({1'b0, sh_bright} + 5'd1);

    assign lit_p0 = (cnt_p0 >= CW'(BLANK_CYCLES)) && (pwm_lhs < pwm_rhs) &&
                    cur_dig[6] && !(cur_blink && blink_ph);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_p0     <= '0;
            idx_p0     <= '0;
            frm_cnt    <= '0;
            blink_ph   <= 1'b0;
            primed     <= 1'b0;
            sh_dig     <= '0;
            sh_blink   <= '0;
            sh_bright  <= '0;
            an         <= '1;
            dec_ddp    <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            cnt_p0 <= cnt_wrap ? '0 : cnt_p0 + CW'(1);
            if (cnt_wrap)
                idx_p0 <= idx_wrap ? '0 : idx_p0 + IW'(1);
            if (snap) begin
                sh_dig    <= dig_in;
                sh_blink  <= blink_mask;
                sh_bright <= brightness;
                primed    <= 1'b1;
                if (frm_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frm_cnt  <= '0;
                    blink_ph <= ~blink_ph;
                end else begin
                    frm_cnt <= frm_cnt + FW'(1);
                end
            end
            // Stage p0 -> output registers: one clock behind the counters.
            an         <= lit_p0 ? an_sel : '1;
            dec_ddp    <= lit_p0 ? {glyph_seg(cur_dig[5:1]), cur_dig[0]} : 8'hFF;
            frame_tick <= primed && (cnt_p0 == '0) && (idx_p0 == '0);
        end
    end

endmodule

// File: tb/tb_dspl_scan_drv.sv
// Directed bench for dspl_scan_drv: table of frame vectors plus hand-written
// sequences for reset, blink, mid-frame input changes and reset mid-scan.
module tb_dspl_scan_drv;

    localparam int ND = 4;
    localparam int CPD = 20;
    localparam int BC = 4;
    localparam int BF = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [27:0] dig_in = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  brightness = '0;
    logic [3:0]  an;
    logic [7:0]  dec_ddp;
    logic        frame_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    dspl_scan_drv #(
        .NUM_DIGITS   (ND),
        .CLK_PER_DIGIT(CPD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .dig_in    (dig_in),
        .blink_mask(blink_mask),
        .brightness(brightness),
        .an        (an),
        .dec_ddp   (dec_ddp),
        .frame_tick(frame_tick)
    );

    // lens: lit cycles per slot, 5 bits each (slot0 in [4:0]); segs: dec_ddp per slot.
    typedef struct {
        logic [27:0] dig;
        logic [3:0]  br;
        logic [19:0] lens;
        logic [31:0] segs;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Releases reset and expects one fully dark frame with no tick, then the first tick.
    task automatic dark_frame(input string tag);
        reset = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            chk($sformatf("%s_dark_c%0d", tag, c), {19'b0, frame_tick, an, dec_ddp},
                {19'b0, 1'b0, 4'hF, 8'hFF});
        end
        @(negedge clock);
        chk({tag, "_first_tick"}, 32'(frame_tick), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [19:0] lens, input logic [31:0] segs,
                               input int chg_c, input logic [27:0] nd, input logic [3:0] nb);
        int         guard;
        int         s;
        int         k;
        logic [4:0] len;
        logic       lit;
        logic [3:0] ea;
        logic [7:0] ed;
        guard = 0;
        while (frame_tick !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk({tag, "_tick_wait"}, 32'(frame_tick), 32'd1);
        for (int c = 0; c < 80; c++) begin
            s   = c / 20;
            k   = c % 20;
            len = lens[5*s +: 5];
            lit = (k >= BC) && (k < BC + int'(len));
            ea  = lit ? ~(4'b0001 << s) : 4'hF;
            ed  = lit ? segs[8*s +: 8] : 8'hFF;
            chk($sformatf("%s_c%0d", tag, c), {19'b0, frame_tick, an, dec_ddp},
                {19'b0, (c == 0), ea, ed});
            if (c == chg_c) begin
                dig_in     = nd;
                brightness = nb;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        vecs[0] = '{dig: {7'h00, 7'h00, 7'h00, 7'h46}, br: 4'hF,
                    lens: {5'd0, 5'd0, 5'd0, 5'd16}, segs: {8'hFF, 8'hFF, 8'hFF, 8'h0C}};
        vecs[1] = '{dig: {7'h00, 7'h00, 7'h00, 7'h46}, br: 4'h7,
                    lens: {5'd0, 5'd0, 5'd0, 5'd8}, segs: {8'hFF, 8'hFF, 8'hFF, 8'h0C}};
        vecs[2] = '{dig: {7'h00, 7'h00, 7'h00, 7'h46}, br: 4'h0,
                    lens: {5'd0, 5'd0, 5'd0, 5'd1}, segs: {8'hFF, 8'hFF, 8'hFF, 8'h0C}};
        vecs[3] = '{dig: {7'h00, 7'h00, 7'h00, 7'h06}, br: 4'hF,
                    lens: {5'd0, 5'd0, 5'd0, 5'd0}, segs: {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[4] = '{dig: {7'h55, 7'h60, 7'h5E, 7'h41}, br: 4'h3,
                    lens: {5'd4, 5'd4, 5'd4, 5'd4}, segs: {8'h31, 8'hFE, 8'h42, 8'h03}};
        vecs[5] = '{dig: {7'h4E, 7'h08, 7'h5B, 7'h4B}, br: 4'hF,
                    lens: {5'd16, 5'd0, 5'd16, 5'd16}, segs: {8'h60, 8'hFF, 8'hE3, 8'h8F}};

        // Reset and first (dark) frame, with vector 0 already presented.
        dig_in     = vecs[0].dig;
        brightness = vecs[0].br;
        blink_mask = 4'b0000;
        reset      = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_out", {19'b0, frame_tick, an, dec_ddp}, {19'b0, 1'b0, 4'hF, 8'hFF});
        dark_frame("first");

        // Each new vector is applied at frame start while the previous one is displayed.
        for (int i = 1; i < 6; i++) begin
            dig_in     = vecs[i].dig;
            brightness = vecs[i].br;
            check_frame($sformatf("vec%0d", i - 1), vecs[i-1].lens, vecs[i-1].segs, -1, '0, '0);
        end
        check_frame("vec5", vecs[5].lens, vecs[5].segs, -1, '0, '0);

        // Inputs change in slot 2; must not show until the next frame.
        check_frame("tear_old", vecs[5].lens, vecs[5].segs, 45, vecs[0].dig, vecs[0].br);
        check_frame("tear_new", vecs[0].lens, vecs[0].segs, -1, '0, '0);

        // Reset asserted while slot 2 is lit.
        dig_in     = vecs[4].dig;
        brightness = vecs[4].br;
        check_frame("pre_rst", vecs[0].lens, vecs[0].segs, -1, '0, '0);
        repeat (44) @(negedge clock);
        chk("an_before_rst", 32'(an), 32'h0000000B);
        reset = 1'b1;
        #1;
        chk("async_rst_out", {19'b0, frame_tick, an, dec_ddp}, {19'b0, 1'b0, 4'hF, 8'hFF});
        repeat (3) @(negedge clock);
        dark_frame("midrst");
        check_frame("post_rst", vecs[4].lens, vecs[4].segs, -1, '0, '0);

        // Blink: digit0 lit in frame 2, dark 3-4, lit 5-6, dark 7.
        reset      = 1'b1;
        dig_in     = {7'h5D, 7'h49, 7'h45, 7'h43};
        brightness = 4'hF;
        blink_mask = 4'b0001;
        repeat (2) @(negedge clock);
        dark_frame("blink");
        check_frame("blink_f2", {5'd16, 5'd16, 5'd16, 5'd16}, {8'h89, 8'h99, 8'h25, 8'h9F}, -1, '0, '0);
        check_frame("blink_f3", {5'd16, 5'd16, 5'd16, 5'd0},  {8'h89, 8'h99, 8'h25, 8'h9F}, -1, '0, '0);
        check_frame("blink_f4", {5'd16, 5'd16, 5'd16, 5'd0},  {8'h89, 8'h99, 8'h25, 8'h9F}, -1, '0, '0);
        check_frame("blink_f5", {5'd16, 5'd16, 5'd16, 5'd16}, {8'h89, 8'h99, 8'h25, 8'h9F}, -1, '0, '0);
        check_frame("blink_f6", {5'd16, 5'd16, 5'd16, 5'd16}, {8'h89, 8'h99, 8'h25, 8'h9F}, -1, '0, '0);
        check_frame("blink_f7", {5'd16, 5'd16, 5'd16, 5'd0},  {8'h89, 8'h99, 8'h25, 8'h9F}, -1, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dspl_scan_drv.md
# dspl_scan_drv

Parametrised multiplexed 7-segment display driver for the Nexys A7 and derived boards. It time-multiplexes `NUM_DIGITS` common-anode digits from a single system clock, with no derived clocks. It adds per-frame input snapshotting to prevent tearing, anode dead time against ghosting, 16-level PWM brightness, and per-digit blinking. It sits between the game/UI logic, which supplies glyph codes, and the board's anode and segment pins.

## Interface
- `NUM_DIGITS`, 8: number of digits scanned; legal range 1..16.
- `CLK_PER_DIGIT`, 100000: clock cycles per digit slot (1 ms at 100 MHz).
- `BLANK_CYCLES`, 1000: dead-time cycles at the start of each slot; must be less than `CLK_PER_DIGIT`.
- `BLINK_FRAMES`, 250: number of frames per blink half-period; must be at least 1.

- `clock`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `dig_in`, in, 7*NUM_DIGITS: digit i occupies `[7i+6:7i]`. Field meanings:
  - bit6: enable.
  - bits5:1: glyph code.
  - bit0: dp level, active-low (0 = dot lit).
- `blink_mask`, in, NUM_DIGITS: bit i = 1 makes digit i blink.
- `brightness`, in, 4: 0 is dimmest, 15 is full on.
- `an`, out, NUM_DIGITS: anodes, active-low; registered.
- `dec_ddp`, out, 8: segments `[7:1]` = a..g, active-low, plus dp on `[0]`; registered.
- `frame_tick`, out, 1: one-cycle pulse at each frame start; registered.

## Operation
- **Counters.**
  - `cnt` runs from 0 to `CLK_PER_DIGIT-1`, then wraps to 0.
  - `idx` advances on each `cnt` wrap, running from 0 to `NUM_DIGITS-1`, then wraps to 0.
  - Slot `idx` drives `an[idx]`. A frame is `NUM_DIGITS*CLK_PER_DIGIT` cycles.
- **Snapshot.** On the clock edge where `cnt` and `idx` both wrap to 0:
  - `dig_in`, `blink_mask` and `brightness` load into shadow registers.
  - Display content comes only from the shadow registers.
  - Input changes mid-frame are invisible until the next frame.
- **Blink phase.**
  - A frame counter toggles `blink_ph` every `BLINK_FRAMES` snapshots.
  - While `blink_ph` = 1, digits whose shadow `blink_mask` bit is set are dark.
- **Lit condition for slot `idx`.** All of the following must hold:
  - `cnt >= BLANK_CYCLES`.
  - `(cnt-BLANK_CYCLES)*16 < (CLK_PER_DIGIT-BLANK_CYCLES)*(brightness+1)`. Compute this at full width; no truncation.
  - The shadow enable bit is 1.
  - The digit is not blinked dark.
- **Outputs when lit.**
  - `an` has only bit `idx` at 0.
  - `dec_ddp[7:1]` = decoded glyph.
  - `dec_ddp[0]` = shadow dp bit.
- **Outputs when not lit.**
  - `an` = all ones.
  - `dec_ddp` = 8'hFF. Segments are always blanked when no anode is active.
- **Glyph decode.** Segment patterns `[7:1]`, active-low:
  - 0x00 "0" = 0000001; 0x01 "1" = 1001111; 0x02 "2" = 0010010; 0x03 "3" = 0000110; 0x04 "4" = 1001100.
  - 0x05 J = 1000111; 0x06 S = 0100100; 0x07 E = 0110000; 0x08 T = 0001111; 0x09 U = 1000001.
  - 0x0A P = 0011000; 0x0B B = 1100000; 0x0C C = 0110001; 0x0D L = 1110001; 0x0E Y = 1000100; 0x0F G = 0100001.
  - 0x10..0x1F: blank (1111111).
- **Reset state.**
  - `cnt` = 0, `idx` = 0, `blink_ph` = 0, frame counter = 0.
  - Shadow registers cleared (all digits disabled, brightness 0).
  - `an` = all ones, `dec_ddp` = 8'hFF, `frame_tick` = 0.
  - Because the shadow is cleared, the first frame after reset is fully dark.

## Timing
- `an`, `dec_ddp` and `frame_tick` are registered from the counter and shadow state, so they lag the counters by exactly one clock.
- **Reference point.** "Slot cycle k" is the output cycle reflecting `cnt` = k. Slot cycle 0 of slot 0 of the first frame is the first rising edge after reset deassertion plus one.
- **`frame_tick`.** High in slot cycle 0 of slot 0 of every frame except the first after reset. It coincides with the first output cycle that uses the newly loaded shadow.
- **Lit window.**
  - Slot cycles 0..`BLANK_CYCLES-1` are always dark.
  - At brightness 15, lit for all of the remaining `CLK_PER_DIGIT-BLANK_CYCLES` cycles.
- **`NUM_DIGITS` = 1.** `idx` stays at 0; a snapshot occurs on every `cnt` wrap.
- **Reset asserted mid-scan.** Outputs go to their reset values asynchronously, within the same cycle. Scanning restarts at slot 0 with a dark frame.

## Test plan
Test parameters: `NUM_DIGITS`=4, `CLK_PER_DIGIT`=20, `BLANK_CYCLES`=4, `BLINK_FRAMES`=2. A frame is 80 cycles.

1. **Reset and first frame.** Hold reset, then release with all digits enabled.
   - Required: `an`=1111 and `dec_ddp`=FF for the whole first frame.
   - Required: `frame_tick` first pulses 80 cycles after the first slot cycle 0.
2. **Digit and dp decode.** Set digit0 = {1, 0x03, 0}, brightness 15.
   - Required: from frame 2, `an`=1110 and `dec_ddp`=8'h0C in slot cycles 4..19 of slot 0.
   - Required: `an`=1111 and `dec_ddp`=FF in slot cycles 0..3.
3. **PWM.**
   - brightness 7: exactly 8 lit cycles per slot, slot cycles 4..11.
   - brightness 0: exactly 1 lit cycle, slot cycle 4.
   - digit0 enable = 0: zero lit cycles.
4. **Blink.** Set `blink_mask`=0001, all digits enabled.
   - Required: digit0 alternates 2 frames lit and 2 frames dark.
   - Required: digits 1..3 are lit in every frame.
5. **Tearing.** Change `dig_in` and `brightness` in slot 2.
   - Required: outputs unchanged for the rest of that frame.
   - Required: new values appear exactly at the next `frame_tick`.
6. **Reset mid-scan.** Assert reset while `an`=1011.
   - Required: `an`=1111 and `dec_ddp`=FF in the same cycle.
   - Required: after release, one dark frame, then normal display.
